// File: rtl/hwpe_stream_fifo_rr_arbiter_pkg.sv
// Shared types for the round-robin FIFO push-port arbiter: status flags and FSM state.
package hwpe_stream_fifo_rr_arbiter_pkg;

    localparam int unsigned ARB_GRANT_W = 8;

    typedef struct packed {
        logic                   busy;
        logic [ARB_GRANT_W-1:0] grant;
    } flags_fifo_arb_t;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/hwpe_stream_fifo_rr_arbiter_if.sv
// HWPE-Stream handshake bundle (valid/ready with data and byte strobes).
interface hwpe_stream_fifo_rr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport master (output valid, output data, output strb, input  ready);
    modport slave  (input  valid, input  data, input  strb, output ready);

endinterface

// File: rtl/hwpe_stream_fifo_rr_arbiter_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping at NB_IN-1.
module hwpe_stream_fifo_rr_arbiter_pick #(
    parameter int unsigned NB_IN = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NB_IN-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int unsigned cand;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NB_IN; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NB_IN) begin
                cand = cand - NB_IN;
            end
            if (!gnt_vld && req[IDX_W'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/hwpe_stream_fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NB_IN producers, with bursts of
// up to MAX_BURST beats per grant; registered grant, combinational data path.
module hwpe_stream_fifo_rr_arbiter
    import hwpe_stream_fifo_rr_arbiter_pkg::*;
#(
    parameter int unsigned NB_IN      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    output flags_fifo_arb_t               flags,
    hwpe_stream_fifo_rr_arbiter_if.slave  push_in [NB_IN],
    hwpe_stream_fifo_rr_arbiter_if.master push_out
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W      = $clog2(NB_IN);
    localparam int unsigned CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NB_IN - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NB_IN-1:0]      in_valid;
    logic [NB_IN-1:0]      in_ready_c;
    logic [DATA_WIDTH-1:0] in_data [NB_IN];
    logic [STRB_WIDTH-1:0] in_strb [NB_IN];

    logic [IDX_W-1:0]      grant_inc;
    logic [IDX_W-1:0]      pick_ptr;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_vld;
    logic                  own_valid;
    logic                  hs;
    logic                  last_beat;
    logic                  burst_end;

    for (genvar i = 0; i < NB_IN; i++) begin : g_in
        assign in_valid[i]      = push_in[i].valid;
        assign in_data[i]       = push_in[i].data;
        assign in_strb[i]       = push_in[i].strb;
        assign push_in[i].ready = in_ready_c[i];
    end

    assign grant_inc = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
    assign own_valid = in_valid[grant_q];
    assign hs        = (state_q == ARB_LOCKED) && own_valid && push_out.ready;
    assign last_beat = hs && (cnt_q == LAST_BEAT);
    assign burst_end = (state_q == ARB_LOCKED) && (last_beat || !own_valid);

    // Scanning from grant_q+1 puts the current owner last, so it only re-wins when alone.
    assign pick_ptr  = (state_q == ARB_LOCKED) ? grant_inc : ptr_q;

    hwpe_stream_fifo_rr_arbiter_pick #(
        .NB_IN (NB_IN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (in_valid),
        .ptr     (pick_ptr),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            ptr_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        state_d = ARB_LOCKED;
                        grant_d = pick_idx;
                        cnt_d   = '0;
                    end
                end
                ARB_LOCKED: begin
                    if (burst_end) begin
                        ptr_d = grant_inc;
                        cnt_d = '0;
                        if (pick_vld) begin
                            grant_d = pick_idx;
                        end else begin
                            state_d = ARB_IDLE;
                        end
                    end else if (hs) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    // Zero-latency data mux from the granted producer; everything quiet while idle.
    always_comb begin
        push_out.valid = 1'b0;
        push_out.data  = '0;
        push_out.strb  = '0;
        in_ready_c     = '0;
        flags          = '0;
        if (state_q == ARB_LOCKED) begin
            push_out.valid      = own_valid;
            push_out.data       = in_data[grant_q];
            push_out.strb       = in_strb[grant_q];
            in_ready_c[grant_q] = push_out.ready;
            flags.busy          = 1'b1;
            flags.grant         = ARB_GRANT_W'(grant_q);
        end
    end

endmodule

// File: tb/tb_hwpe_stream_fifo_rr_arbiter.sv
// Scoreboard bench for the round-robin FIFO arbiter: three configurations share one
// producer/FIFO model, selected by sel; a monitor pops expected beats on every handshake.
module tb_hwpe_stream_fifo_rr_arbiter;
    import hwpe_stream_fifo_rr_arbiter_pkg::*;

    localparam int unsigned DW = 32;

    typedef struct {
        int          src;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic            out_ready;
    logic [1:0]      sel;

    int              rem [4];
    int              seq [4];
    logic [3:0]      src_valid;
    logic [DW-1:0]   src_data [4];

    logic            o_valid;
    logic [DW-1:0]   o_data;
    logic [3:0]      o_strb;
    logic [3:0]      o_rdy;
    flags_fifo_arb_t o_flags;

    exp_t            exp_q [$];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src_valid[i] = (rem[i] > 0);
            src_data[i]  = {8'(i), 24'(seq[i])};
        end
    end

    // Instance A: 4 sources, bursts of 8
    hwpe_stream_fifo_rr_arbiter_if #(.DATA_WIDTH(DW)) a_in [4] ();
    hwpe_stream_fifo_rr_arbiter_if #(.DATA_WIDTH(DW)) a_out ();
    flags_fifo_arb_t a_flags;
    logic [3:0]      a_rdy;
    for (genvar g = 0; g < 4; g++) begin : g_a
        assign a_in[g].valid = src_valid[g] && (sel == 2'd0);
        assign a_in[g].data  = src_data[g];
        assign a_in[g].strb  = '1;
        assign a_rdy[g]      = a_in[g].ready;
    end
    assign a_out.ready = out_ready && (sel == 2'd0);

    hwpe_stream_fifo_rr_arbiter #(.NB_IN(4), .DATA_WIDTH(DW), .MAX_BURST(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .flags(a_flags),
        .push_in(a_in), .push_out(a_out)
    );

    // Instance B: 4 sources, bursts of 2
    hwpe_stream_fifo_rr_arbiter_if #(.DATA_WIDTH(DW)) b_in [4] ();
    hwpe_stream_fifo_rr_arbiter_if #(.DATA_WIDTH(DW)) b_out ();
    flags_fifo_arb_t b_flags;
    logic [3:0]      b_rdy;
    for (genvar g = 0; g < 4; g++) begin : g_b
        assign b_in[g].valid = src_valid[g] && (sel == 2'd1);
        assign b_in[g].data  = src_data[g];
        assign b_in[g].strb  = '1;
        assign b_rdy[g]      = b_in[g].ready;
    end
    assign b_out.ready = out_ready && (sel == 2'd1);

    hwpe_stream_fifo_rr_arbiter #(.NB_IN(4), .DATA_WIDTH(DW), .MAX_BURST(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .flags(b_flags),
        .push_in(b_in), .push_out(b_out)
    );

    // Instance C: 3 sources, one beat per grant
    hwpe_stream_fifo_rr_arbiter_if #(.DATA_WIDTH(DW)) c_in [3] ();
    hwpe_stream_fifo_rr_arbiter_if #(.DATA_WIDTH(DW)) c_out ();
    flags_fifo_arb_t c_flags;
    logic [2:0]      c_rdy;
    for (genvar g = 0; g < 3; g++) begin : g_c
        assign c_in[g].valid = src_valid[g] && (sel == 2'd2);
        assign c_in[g].data  = src_data[g];
        assign c_in[g].strb  = '1;
        assign c_rdy[g]      = c_in[g].ready;
    end
    assign c_out.ready = out_ready && (sel == 2'd2);

    hwpe_stream_fifo_rr_arbiter #(.NB_IN(3), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .flags(c_flags),
        .push_in(c_in), .push_out(c_out)
    );

    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        o_strb  = '0;
        o_rdy   = '0;
        o_flags = '0;
        case (sel)
            2'd0: begin
                o_valid = a_out.valid; o_data = a_out.data; o_strb = a_out.strb;
                o_rdy   = a_rdy;       o_flags = a_flags;
            end
            2'd1: begin
                o_valid = b_out.valid; o_data = b_out.data; o_strb = b_out.strb;
                o_rdy   = b_rdy;       o_flags = b_flags;
            end
            default: begin
                o_valid = c_out.valid; o_data = c_out.data; o_strb = c_out.strb;
                o_rdy   = {1'b0, c_rdy}; o_flags = c_flags;
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 32'(o_valid), 32'd0);
        check({name, "_ready"}, 32'(o_rdy), 32'd0);
        check({name, "_busy"},  32'(o_flags.busy), 32'd0);
        check({name, "_grant"}, 32'(o_flags.grant), 32'd0);
    endtask

    task automatic exp_run(input int s, input int first, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.src  = s;
            e.data = {8'(s), 24'(first + k)};
            exp_q.push_back(e);
        end
    endtask

    task automatic start_test(input logic [1:0] s);
        sel = s;
        for (int i = 0; i < 4; i++) seq[i] = 0;
    endtask

    // Wait for all producers to drain; optionally check the cycle count (no bubbles).
    task automatic wait_done(input string name, input int exp_cyc);
        int cyc;
        cyc = 0;
        while (((rem[0] | rem[1] | rem[2] | rem[3]) != 0) && (cyc < 300)) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check({name, "_done"}, 32'(cyc < 300), 32'd1);
        if (exp_cyc >= 0) check({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        repeat (3) @(posedge clk);
        #1;
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle_busy"}, 32'(o_flags.busy), 32'd0);
    endtask

    // Producer model: advance a source only after a sampled valid&ready handshake.
    initial begin
        logic [3:0] hs;
        forever begin
            @(negedge clk);
            hs = src_valid & o_rdy;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) begin
                    seq[i] = seq[i] + 1;
                    rem[i] = rem[i] - 1;
                end
            end
        end
    end

    // Monitor: every accepted beat must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none at %0t", o_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_grant", 32'(o_flags.grant), 32'(e.src));
                    check("beat_data", o_data, e.data);
                    check("beat_strb", 32'(o_strb), 32'hF);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        sel       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            check_idle("reset");
        end
        @(posedge clk);
        #1;

        // Single source, bursts of 8 with back-to-back re-grant
        start_test(2'd0);
        rem[1] = 20;
        exp_run(1, 0, 20);
        wait_done("single_src", 21);

        // All four valid, bursts of 2
        start_test(2'd1);
        for (int i = 0; i < 4; i++) rem[i] = 4;
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++) exp_run(s, 2 * r, 2);
        wait_done("rr_burst2", 17);

        // src2 drops valid after 3 beats while src0 waits
        start_test(2'd0);
        rem[2] = 3;
        rem[0] = 2;
        exp_run(2, 0, 3);
        exp_run(0, 0, 2);
        wait_done("valid_drop", 7);

        // Backpressure mid-burst; src0 pending would steal the grant if cnt advanced
        start_test(2'd0);
        rem[3] = 6;
        rem[0] = 2;
        exp_run(3, 0, 6);
        exp_run(0, 0, 2);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(o_valid), 32'd1);
            check("stall_grant", 32'(o_flags.grant), 32'd3);
            check("stall_data", o_data, {8'd3, 24'd2});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("backpressure", -1);

        // Soft clear with cnt=3; the beat presented during the clear cycle is still taken
        start_test(2'd0);
        rem[1] = 10;
        exp_run(1, 0, 4);
        exp_run(0, 0, 2);
        exp_run(1, 4, 6);
        repeat (4) @(posedge clk);
        #1;
        clear  = 1'b1;
        rem[0] = 2;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check_idle("clear");
        wait_done("clear", -1);

        // Async reset with cnt=3; in-flight beat must not be accepted
        start_test(2'd0);
        rem[3] = 10;
        exp_run(3, 0, 3);
        exp_run(0, 0, 2);
        exp_run(3, 3, 7);
        repeat (4) @(posedge clk);
        #1;
        rst_n  = 1'b0;
        rem[0] = 2;
        @(negedge clk);
        check_idle("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_done("async_rst", -1);

        // Three sources, one beat per grant
        start_test(2'd2);
        for (int i = 0; i < 3; i++) rem[i] = 2;
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 3; s++) exp_run(s, r, 1);
        wait_done("nb3_burst1", 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
